// File: rtl/cache_sram_nway.sv
// N-way set-associative line store: combinational lookup/victim selection,
// age-counter LRU, and a flush engine that writes back dirty lines in set/way order.
module cache_sram_nway #(
  parameter int WAYS   = 4,
  parameter int SETS   = 4,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [29:0]       addr_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic              dirty_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o,
  output logic              hit_o,
  output logic              vic_valid_o,
  output logic              vic_dirty_o,
  output logic [27:0]       vic_addr_o,
  input  logic              flush_i,
  output logic              flush_busy_o,
  output logic              flush_done_o,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [27:0]       wb_addr_o,
  output logic [LINE_W-1:0] wb_data_o
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WB} state_t;

  logic              valid_q [SETS][WAYS];
  logic              dirty_q [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic [WAY_W-1:0]  age_q   [SETS][WAYS];

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ps_q, ps_d;
  logic [WAY_W-1:0] pw_q, pw_d;
  logic             done_q, done_d;
  logic             clr_dirty, adv, last_entry, busy, touch;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit_any, inv_any;
  logic [WAY_W-1:0] hit_way, inv_way, lru_way, sel;
  logic [WAY_W-1:0] old_age;
  logic             unused_offset;

  assign idx           = addr_i[IDX_W+1:2];
  assign tag           = addr_i[29:IDX_W+2];
  assign unused_offset = ^addr_i[1:0];

  // Descending scan so the lowest-index match wins.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    lru_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
      if (age_q[idx][w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
    end
    sel = hit_any ? hit_way : (inv_any ? inv_way : lru_way);
  end

  assign busy         = (state_q != S_IDLE);
  assign touch        = !busy && (write_i || (read_i && hit_any));
  assign old_age      = age_q[idx][sel];
  assign hit_o        = hit_any && !busy;
  assign rdata_o      = data_q[idx][sel];
  assign vic_valid_o  = valid_q[idx][sel];
  assign vic_dirty_o  = dirty_q[idx][sel];
  assign vic_addr_o   = {tag_q[idx][sel], idx};
  assign flush_busy_o = busy;
  assign flush_done_o = done_q;
  assign wb_addr_o    = {tag_q[ps_q][pw_q], ps_q};
  assign wb_data_o    = data_q[ps_q][pw_q];
  assign last_entry   = (ps_q == IDX_W'(SETS - 1)) && (pw_q == WAY_W'(WAYS - 1));

  always_comb begin
    state_d    = state_q;
    ps_d       = ps_q;
    pw_d       = pw_q;
    done_d     = 1'b0;
    wb_valid_o = 1'b0;
    clr_dirty  = 1'b0;
    adv        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          state_d = S_SCAN;
          ps_d    = '0;
          pw_d    = '0;
        end
      end
      S_SCAN: begin
        if (valid_q[ps_q][pw_q] && dirty_q[ps_q][pw_q]) state_d = S_WB;
        else adv = 1'b1;
      end
      S_WB: begin
        wb_valid_o = 1'b1;
        if (wb_ready_i) begin
          clr_dirty = 1'b1;
          adv       = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Pointer walks ways first, then sets; the final entry ends the flush.
    if (adv) begin
      if (last_entry) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = S_SCAN;
        if (pw_q == WAY_W'(WAYS - 1)) begin
          pw_d = '0;
          ps_d = ps_q + 1'b1;
        end else begin
          pw_d = pw_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ps_q    <= '0;
      pw_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      pw_q    <= pw_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          data_q[s][w]  <= '0;
          age_q[s][w]   <= WAY_W'(w);
        end
      end
    end else begin
      if (touch) begin
        if (write_i) begin
          valid_q[idx][sel] <= 1'b1;
          dirty_q[idx][sel] <= dirty_i;
          tag_q[idx][sel]   <= tag;
          data_q[idx][sel]  <= wdata_i;
        end
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == sel) age_q[idx][w] <= '0;
          else if (age_q[idx][w] < old_age) age_q[idx][w] <= age_q[idx][w] + 1'b1;
        end
      end
      if (clr_dirty) dirty_q[ps_q][pw_q] <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cache_sram_nway.sv
// Bench for cache_sram_nway: directed scenarios plus random traffic checked
// against a recency-list cache model and a write-back scoreboard.
module tb_cache_sram_nway;
  localparam int WAYS   = 4;
  localparam int SETS   = 4;
  localparam int LINE_W = 128;
  localparam int IDX_W  = 2;
  localparam int TAG_W  = 26;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [29:0]       addr_i = '0;
  logic              read_i = 1'b0, write_i = 1'b0, dirty_i = 1'b0;
  logic [LINE_W-1:0] wdata_i = '0;
  logic [LINE_W-1:0] rdata_o;
  logic              hit_o, vic_valid_o, vic_dirty_o;
  logic [27:0]       vic_addr_o;
  logic              flush_i = 1'b0;
  logic              flush_busy_o, flush_done_o, wb_valid_o;
  logic              wb_ready_i = 1'b0;
  logic [27:0]       wb_addr_o;
  logic [LINE_W-1:0] wb_data_o;

  always #5 clk = ~clk;

  cache_sram_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .read_i(read_i), .write_i(write_i),
    .dirty_i(dirty_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .hit_o(hit_o),
    .vic_valid_o(vic_valid_o), .vic_dirty_o(vic_dirty_o), .vic_addr_o(vic_addr_o),
    .flush_i(flush_i), .flush_busy_o(flush_busy_o), .flush_done_o(flush_done_o),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_addr_o(wb_addr_o),
    .wb_data_o(wb_data_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: m_lru[s] is a recency list, most recent first.
  bit                m_valid [SETS][WAYS];
  bit                m_dirty [SETS][WAYS];
  logic [TAG_W-1:0]  m_tag   [SETS][WAYS];
  logic [LINE_W-1:0] m_data  [SETS][WAYS];
  int                m_lru   [SETS][WAYS];
  bit                m_busy;

  function automatic int a_set(input logic [29:0] a);
    return int'(a[IDX_W+1:2]);
  endfunction

  function automatic logic [TAG_W-1:0] a_tag(input logic [29:0] a);
    return a[29:IDX_W+2];
  endfunction

  function automatic int m_pick(input logic [29:0] a, output bit h);
    int s, way;
    s = a_set(a);
    h = 1'b0;
    way = -1;
    for (int w = 0; w < WAYS; w++)
      if (!h && m_valid[s][w] && m_tag[s][w] == a_tag(a)) begin h = 1'b1; way = w; end
    if (!h)
      for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) way = w;
    if (way < 0) way = m_lru[s][WAYS-1];
    return way;
  endfunction

  function automatic void m_touch(input int s, input int way);
    int p;
    p = 0;
    for (int i = 0; i < WAYS; i++) if (m_lru[s][i] == way) p = i;
    for (int i = p; i > 0; i--) m_lru[s][i] = m_lru[s][i-1];
    m_lru[s][0] = way;
  endfunction

  function automatic void m_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0; m_dirty[s][w] = 1'b0;
        m_tag[s][w] = '0; m_data[s][w] = '0; m_lru[s][w] = w;
      end
    m_busy = 1'b0;
  endfunction

  function automatic logic [LINE_W-1:0] rnd_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [29:0] rnd_addr();
    int t, s, o;
    t = $urandom_range(0, 6); s = $urandom_range(0, SETS - 1); o = $urandom_range(0, 3);
    return 30'((t << (IDX_W + 2)) | (s << 2) | o);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b0; dirty_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic apply(input bit rd, input bit wr, input bit dty, input logic [29:0] a,
                       input logic [LINE_W-1:0] d);
    @(negedge clk);
    read_i = rd; write_i = wr; dirty_i = dty; addr_i = a; wdata_i = d;
    flush_i = 1'b0; wb_ready_i = 1'b0;
    #1;
  endtask

  // Advances the model with the inputs currently driven, then takes the edge.
  task automatic commit();
    bit h;
    int s, w;
    if (!m_busy && (write_i || read_i)) begin
      s = a_set(addr_i);
      w = m_pick(addr_i, h);
      if (write_i) begin
        m_valid[s][w] = 1'b1; m_dirty[s][w] = dirty_i;
        m_tag[s][w] = a_tag(addr_i); m_data[s][w] = wdata_i;
        m_touch(s, w);
      end else if (h) begin
        m_touch(s, w);
      end
    end
    @(posedge clk);
  endtask

  task automatic do_flush(input bit stall_first, input string nm);
    logic [27:0]       ea[$];
    logic [LINE_W-1:0] exp_q[$];
    logic [27:0]       ha;
    logic [LINE_W-1:0] hd;
    logic [27:0]       xa;
    logic [LINE_W-1:0] xd;
    int stall, hs;
    bit seen_first, fin;
    stall = 0; hs = 0; seen_first = 1'b0; fin = 1'b0; ha = '0; hd = '0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++)
        if (m_valid[s][w] && m_dirty[s][w]) begin
          ea.push_back({m_tag[s][w], IDX_W'(s)});
          exp_q.push_back(m_data[s][w]);
        end
    m_busy = 1'b1;
    for (int c = 0; c < 500 && !fin; c++) begin
      @(negedge clk);
      flush_i = 1'b0; write_i = 1'b0; read_i = 1'b0;
      if (stall_first && hs == 0) wb_ready_i = (stall >= 3);
      else wb_ready_i = 1'($urandom_range(0, 1));
      #1;
      if (flush_done_o) begin
        fin = 1'b1;
        n_tests++;
        if (flush_busy_o !== 1'b0 || wb_valid_o !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_done_state: busy=%b wb_valid=%b want 0/0", nm, flush_busy_o, wb_valid_o);
        end
      end else begin
        n_tests++;
        if (flush_busy_o !== 1'b1 || hit_o !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_busy: busy=%b hit=%b want 1/0", nm, flush_busy_o, hit_o);
        end
        if (wb_valid_o) begin
          if (stall_first && hs == 0) begin
            if (!seen_first) begin
              ha = wb_addr_o; hd = wb_data_o; seen_first = 1'b1;
            end else begin
              n_tests++;
              if (wb_addr_o !== ha || wb_data_o !== hd) begin
                n_fail++;
                $display("FAIL %s_stable: addr=%h want %h", nm, wb_addr_o, ha);
              end
            end
            stall++;
          end
          if (wb_ready_i) begin
            n_tests++;
            if (ea.size() == 0) begin
              n_fail++;
              $display("FAIL %s_extra_wb: addr=%h want none", nm, wb_addr_o);
            end else begin
              xa = ea.pop_front();
              xd = exp_q.pop_front();
              if (wb_addr_o !== xa || wb_data_o !== xd) begin
                n_fail++;
                $display("FAIL %s_wb: addr=%h data=%h want addr=%h data=%h", nm, wb_addr_o, wb_data_o, xa, xd);
              end
            end
            hs++;
          end
        end
      end
    end
    n_tests++;
    if (!fin || ea.size() != 0) begin
      n_fail++;
      $display("FAIL %s_complete: done_seen=%0d missing_wb=%0d want 1/0", nm, fin, ea.size());
    end
    @(negedge clk);
    wb_ready_i = 1'b0;
    #1;
    n_tests++;
    if (flush_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_pulse: done=%b want 0", nm, flush_done_o);
    end
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) m_dirty[s][w] = 1'b0;
    m_busy = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    apply(1, 0, 0, rnd_addr(), '0);
    n_tests++;
    if (hit_o !== 0 || flush_busy_o !== 0 || flush_done_o !== 0 || wb_valid_o !== 0 ||
        vic_valid_o !== 0 || vic_dirty_o !== 0 || rdata_o !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: hit=%b busy=%b done=%b wbv=%b vv=%b vd=%b want all 0",
               hit_o, flush_busy_o, flush_done_o, wb_valid_o, vic_valid_o, vic_dirty_o);
    end
    apply(0, 1, 1, 30'h024, rnd_line());
    commit();
    do_reset();
    apply(1, 0, 0, 30'h024, '0);
    n_tests++;
    if (hit_o !== 0 || vic_valid_o !== 0 || vic_dirty_o !== 0) begin
      n_fail++;
      $display("FAIL reset_clears: hit=%b vv=%b vd=%b want 0/0/0", hit_o, vic_valid_o, vic_dirty_o);
    end
  endtask

  task automatic test_cold_fill();
    logic [LINE_W-1:0] d[4];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      d[i] = rnd_line();
      apply(0, 1, 0, 30'(i * 16), d[i]);
      n_tests++;
      if (vic_valid_o !== 1'b0 || hit_o !== 1'b0) begin
        n_fail++;
        $display("FAIL cold_fill_vic[%0d]: vv=%b hit=%b want 0/0", i, vic_valid_o, hit_o);
      end
      commit();
    end
    for (int i = 3; i >= 0; i--) begin
      apply(1, 0, 0, 30'(i * 16), '0);
      n_tests++;
      if (hit_o !== 1'b1 || rdata_o !== d[i] || vic_addr_o !== 28'(i * 4)) begin
        n_fail++;
        $display("FAIL cold_fill_read[%0d]: hit=%b addr=%h want 1 %h", i, hit_o, vic_addr_o, 28'(i * 4));
      end
      commit();
    end
  endtask

  task automatic test_lru();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, 0, 30'(i * 16), rnd_line());
      commit();
    end
    apply(1, 0, 0, 30'h000, '0);
    commit();
    apply(1, 0, 0, 30'h040, '0);
    n_tests++;
    if (hit_o !== 1'b0 || vic_valid_o !== 1'b1 || vic_addr_o !== 28'h004) begin
      n_fail++;
      $display("FAIL lru_victim: hit=%b vv=%b addr=%h want 0 1 004", hit_o, vic_valid_o, vic_addr_o);
    end
    commit();
    apply(0, 1, 0, 30'h040, rnd_line());
    commit();
    apply(1, 0, 0, 30'h010, '0);
    n_tests++;
    if (hit_o !== 1'b0) begin
      n_fail++;
      $display("FAIL lru_evicted: hit=%b want 0", hit_o);
    end
    commit();
  endtask

  task automatic test_dirty_victim();
    do_reset();
    apply(0, 1, 1, 30'h000, rnd_line());
    commit();
    for (int i = 1; i < 4; i++) begin
      apply(0, 1, 0, 30'(i * 16), rnd_line());
      commit();
    end
    apply(0, 1, 0, 30'h040, rnd_line());
    n_tests++;
    if (vic_dirty_o !== 1'b1 || vic_valid_o !== 1'b1 || vic_addr_o !== 28'h000) begin
      n_fail++;
      $display("FAIL dirty_victim: vd=%b vv=%b addr=%h want 1 1 000", vic_dirty_o, vic_valid_o, vic_addr_o);
    end
    commit();
  endtask

  task automatic test_flush_bp();
    bit h;
    int w, s;
    do_reset();
    apply(0, 1, 1, 30'h000, rnd_line()); commit();
    apply(0, 1, 0, 30'h00C, rnd_line()); commit();
    apply(0, 1, 1, 30'h01C, rnd_line()); commit();
    apply(0, 0, 0, 30'h000, '0);
    flush_i = 1'b1;
    commit();
    m_busy = 1'b1;
    // A write while busy must be dropped.
    apply(1, 1, 1, 30'h060, rnd_line());
    n_tests++;
    if (flush_busy_o !== 1'b1 || wb_valid_o !== 1'b0 || hit_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_bp_scan: busy=%b wbv=%b hit=%b want 1/0/0", flush_busy_o, wb_valid_o, hit_o);
    end
    commit();
    do_flush(1, "flush_bp");
    for (int i = 0; i < 3; i++) begin
      logic [29:0] a;
      a = (i == 0) ? 30'h000 : (i == 1) ? 30'h01C : 30'h060;
      apply(0, 0, 0, a, '0);
      w = m_pick(a, h);
      s = a_set(a);
      n_tests++;
      if (hit_o !== h || vic_dirty_o !== 1'b0 || rdata_o !== m_data[s][w]) begin
        n_fail++;
        $display("FAIL flush_bp_after[%0d]: hit=%b vd=%b want %b 0", i, hit_o, vic_dirty_o, h);
      end
    end
  endtask

  task automatic test_simul_and_reset();
    bit seen;
    do_reset();
    apply(0, 1, 1, 30'h050, rnd_line());
    flush_i = 1'b1;
    commit();
    do_flush(0, "simul");
    apply(0, 1, 1, 30'h000, rnd_line()); commit();
    apply(0, 0, 0, 30'h000, '0);
    flush_i = 1'b1;
    commit();
    m_busy = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      flush_i = 1'b0; wb_ready_i = 1'b0;
      #1;
      if (wb_valid_o) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rst_wb_request: wb_valid never seen, want 1");
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    #1;
    n_tests++;
    if (wb_valid_o !== 1'b0 || flush_busy_o !== 1'b0 || flush_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_wb: wbv=%b busy=%b done=%b want 0/0/0", wb_valid_o, flush_busy_o, flush_done_o);
    end
    for (int i = 0; i < 2; i++) begin
      apply(1, 0, 0, (i == 0) ? 30'h000 : 30'h050, '0);
      n_tests++;
      if (hit_o !== 1'b0 || vic_valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_lookup[%0d]: hit=%b vv=%b want 0/0", i, hit_o, vic_valid_o);
      end
    end
  endtask

  task automatic test_random();
    bit h;
    int w, s;
    logic [29:0] a;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 120; n++) begin
        a = rnd_addr();
        apply(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), a, rnd_line());
        w = m_pick(a, h);
        s = a_set(a);
        n_tests++;
        if (hit_o !== h || rdata_o !== m_data[s][w] || vic_valid_o !== m_valid[s][w] ||
            vic_dirty_o !== m_dirty[s][w] || vic_addr_o !== {m_tag[s][w], IDX_W'(s)}) begin
          n_fail++;
          $display("FAIL random_lookup[%0d.%0d]: a=%h hit=%b vv=%b vd=%b va=%h want %b %b %b %h",
                   r, n, a, hit_o, vic_valid_o, vic_dirty_o, vic_addr_o,
                   h, m_valid[s][w], m_dirty[s][w], {m_tag[s][w], IDX_W'(s)});
        end
        commit();
      end
      apply(0, 1'($urandom_range(0, 1)), 1'b1, rnd_addr(), rnd_line());
      flush_i = 1'b1;
      commit();
      do_flush(0, "random_flush");
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_cold_fill();
    test_lru();
    test_dirty_victim();
    test_flush_bp();
    test_simul_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
